// File: rtl/queue_ctrl.sv
// -----------------------------------------------------------------------------
// queue_ctrl
//
// Fill controller for the 4-byte instruction queue (an 8-bit-in, 32-bit-out
// shift register). It fetches bytes from instruction memory over a req/ack
// handshake. Each accepted byte pulses the queue shift enable. The controller
// tracks how many fresh bytes the queue holds, and presents the word as valid
// to the decoder once all four bytes are fresh.
//
// Ports
//   clk         in   system clock, rising edge
//   rst         in   asynchronous reset, active low
//   mem_req     out  byte fetch request
//   mem_addr    out  byte address of the current fetch (the program counter)
//   mem_ack     in   memory data valid this cycle (data goes straight to queue)
//   q_en        out  queue shift enable, same edge as the accepted byte
//   q_valid     out  queue holds 4 fresh bytes
//   q_count     out  number of fresh bytes in the queue, 0..4
//   word_addr   out  address of the oldest byte (queue MSB byte)
//   dec_take    in   decoder consumes the current word
//   flush       in   branch/redirect, discard queue contents
//   flush_addr  in   new fetch address on flush
//   bus_err     out  fetch timeout flag
//
// Optional feature (macro QCTRL_TIMEOUT_EN): a wait counter moves the
// controller to an error state after TIMEOUT fetch cycles without mem_ack.
// Only flush or reset leave that state. When the macro is undefined, bus_err
// is tied low and a fetch waits for an ack indefinitely.
// -----------------------------------------------------------------------------
module queue_ctrl #(
    parameter int unsigned       ADDR_W     = 16,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
    parameter int unsigned       TIMEOUT    = 15
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    output logic              q_en,
    output logic              q_valid,
    output logic [2:0]        q_count,
    output logic [ADDR_W-1:0] word_addr,
    input  logic              dec_take,
    input  logic              flush,
    input  logic [ADDR_W-1:0] flush_addr,
    output logic              bus_err
);

    // The wait counter is 4 bits wide, so TIMEOUT must fit in 1..15.
    if (TIMEOUT == 0 || TIMEOUT > 15) begin : g_bad_timeout
        $error("queue_ctrl: TIMEOUT must be in 1..15");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_FULL
`ifdef QCTRL_TIMEOUT_EN
        , ST_ERR
`endif
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] word_addr_q, word_addr_d;
    logic [2:0]        count_q, count_d;

`ifdef QCTRL_TIMEOUT_EN
    localparam logic [3:0] WAIT_LAST = 4'(TIMEOUT - 1);

    logic [3:0] wait_q, wait_d;
    logic       bus_err_q, bus_err_d;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            pc_q        <= RESET_ADDR;
            word_addr_q <= RESET_ADDR;
            count_q     <= '0;
`ifdef QCTRL_TIMEOUT_EN
            wait_q      <= '0;
            bus_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            word_addr_q <= word_addr_d;
            count_q     <= count_d;
`ifdef QCTRL_TIMEOUT_EN
            wait_q      <= wait_d;
            bus_err_q   <= bus_err_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        word_addr_d = word_addr_q;
        count_d     = count_q;
        mem_req     = 1'b0;
        q_en        = 1'b0;
`ifdef QCTRL_TIMEOUT_EN
        wait_d      = wait_q;
        bus_err_d   = bus_err_q;
`endif

        // Flush overrides everything outside IDLE. A coincident ack is
        // dropped (no shift) and a coincident take is ignored.
        if (flush && state_q != ST_IDLE) begin
            state_d     = ST_FETCH;
            pc_d        = flush_addr;
            word_addr_d = flush_addr;
            count_d     = '0;
`ifdef QCTRL_TIMEOUT_EN
            wait_d      = '0;
            bus_err_d   = 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_FETCH;
`ifdef QCTRL_TIMEOUT_EN
                    wait_d  = '0;
`endif
                end
                ST_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ack) begin
                        q_en    = 1'b1;
                        pc_d    = pc_q + ADDR_W'(1);
                        count_d = count_q + 3'd1;
                        // The first fresh byte becomes the oldest byte of the word.
                        if (count_q == 3'd0) begin
                            word_addr_d = pc_q;
                        end
                        if (count_q == 3'd3) begin
                            state_d = ST_FULL;
                        end
`ifdef QCTRL_TIMEOUT_EN
                        wait_d = '0;
                    end else if (wait_q == WAIT_LAST) begin
                        state_d   = ST_ERR;
                        bus_err_d = 1'b1;
                    end else begin
                        wait_d = wait_q + 4'd1;
`endif
                    end
                end
                ST_FULL: begin
                    // Queue is held. Consuming the word restarts the fill;
                    // the stale bytes get shifted out by the refill.
                    if (dec_take) begin
                        count_d = '0;
                        state_d = ST_FETCH;
`ifdef QCTRL_TIMEOUT_EN
                        wait_d  = '0;
`endif
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    assign mem_addr  = pc_q;
    assign q_valid   = (state_q == ST_FULL);
    assign q_count   = count_q;
    assign word_addr = word_addr_q;

`ifdef QCTRL_TIMEOUT_EN
    assign bus_err = bus_err_q;
`else
    assign bus_err = 1'b0;
`endif

endmodule

// File: doc/queue_ctrl.md
Name: queue_ctrl

Overview:
- Fill controller for the 4-byte instruction queue (shift register, 8-bit in, 32-bit word out).
- Issues byte fetches to instruction memory over a req/ack handshake and pulses the queue shift enable on each accepted byte.
- Tracks fill level and presents a valid 32-bit word to the decoder.
- Handles decoder consume and branch flush; sits between the memory interface, the queue and the decoder.

Parameters:
- ADDR_W, 16, width of fetch address and program counter.
- RESET_ADDR, 0, fetch address loaded at reset.
- TIMEOUT, 15, max cycles waiting for mem_ack (used only with QCTRL_TIMEOUT_EN).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- mem_req  out  1  byte fetch request.
- mem_addr  out  ADDR_W  byte address of current fetch.
- mem_ack  in  1  memory data valid this cycle; memory data bus is wired directly to the queue data input at top level.
- q_en  out  1  shift enable to the queue.
- q_valid  out  1  queue holds 4 fresh bytes; word valid to decoder.
- q_count  out  3  fresh bytes in queue, 0..4.
- word_addr  out  ADDR_W  address of oldest byte (queue MSB byte) of the current word.
- dec_take  in  1  decoder consumes the word.
- flush  in  1  branch/redirect; discard queue contents.
- flush_addr  in  ADDR_W  new fetch address on flush.
- bus_err  out  1  fetch timeout flag (QCTRL_TIMEOUT_EN only; else tied 0).

Behaviour:
- States: IDLE, FETCH, FULL (plus ERR with feature).
- Reset (rst=0, async):
  - state=IDLE, pc=RESET_ADDR, word_addr=RESET_ADDR, q_count=0.
  - mem_req=0, q_en=0, q_valid=0, bus_err=0.
- IDLE -> FETCH unconditionally on the first clk edge after reset release.
- mem_req = (state==FETCH) & ~flush, combinational. mem_addr = pc.
- mem_req is held high until mem_ack. The memory may ack in the same cycle as req; mem_ack outside FETCH is ignored.
- q_en = (state==FETCH) & mem_ack & ~flush, combinational, so the queue captures the byte on the same edge.
- On an accepted byte: pc<=pc+1 (wraps modulo 2^ADDR_W), q_count<=q_count+1.
  - If q_count was 0: word_addr<=pc.
  - If q_count was 3: state<=FULL.
- FULL: q_valid=1 (q_valid = state==FULL), mem_req=0, q_en=0. The queue is held; no overwrite.
- dec_take in FULL: q_count<=0, state<=FETCH. q_valid drops next cycle; one-cycle bubble before the next req.
- dec_take outside FULL is ignored.
- flush (any state except IDLE) has highest priority:
  - Next edge: pc<=flush_addr, word_addr<=flush_addr, q_count<=0, state<=FETCH, bus_err<=0.
  - A coincident mem_ack is discarded (q_en=0). A coincident dec_take is ignored.
- Stale bytes are never cleared; they are shifted out by the 4 refill bytes, and q_valid gates them.
- Reset mid-fetch: immediate return to reset values. Any outstanding memory response after reset is dropped, because the controller returns to IDLE.

Optional Feature:
- Macro: QCTRL_TIMEOUT_EN.
- With the macro:
  - A 4-bit wait counter clears on entry to FETCH and on each ack, and increments each FETCH cycle without ack.
  - When the count reaches TIMEOUT: state<=ERR, bus_err<=1.
  - In ERR: mem_req=0, q_en=0, q_valid=0. Only flush or reset exits; flush clears bus_err and enters FETCH.
- Without the macro: no counter and no ERR state; bus_err tied 0; FETCH waits for ack indefinitely.

Test Plan:
- Reset, ack every cycle -> mem_addr 0,1,2,3; four q_en pulses; q_count 1..4; q_valid=1 in the cycle after the 4th ack; word_addr=0; mem_req=0 while FULL.
- FULL, dec_take=1 for 1 cycle -> q_valid=0 and q_count=0 next cycle; mem_req=1 with mem_addr=4 one cycle later; word_addr=4 after the next ack.
- Acks delayed 3 cycles each -> mem_req held and mem_addr stable while waiting; exactly one q_en per ack; q_valid only after 4 acks.
- Flush with flush_addr=0x1234 after 2 bytes, mem_ack coincident -> no q_en that cycle; q_count=0; next mem_addr=0x1234; word_addr=0x1234; dec_take in the same cycle has no effect.
- pc=0xFFFE, 4 acks -> mem_addr sequence FFFE, FFFF, 0000, 0001; word_addr=0xFFFE.
- With QCTRL_TIMEOUT_EN, TIMEOUT=15, no ack -> bus_err=1 after 15 FETCH cycles; mem_req=0; flush to 0x0010 -> bus_err=0 and mem_req=1 with mem_addr=0x0010.
